// File: rtl/mem_initiator.sv
// mem_initiator: arbitrates fetch and load/store requests onto a registered-read memory and returns one response per accept
module mem_initiator #(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_fault,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_fault,
  output logic        mem_write_mem,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  state_t      state;
  logic        owner;
  logic        zero_data;
  logic        fault_q;
  logic        hold_fault;
  logic [31:0] hold_data;
  logic        own_ready;
  logic        eligible;
  logic        d_win;
  logic        i_win;
  logic        accept;
  logic        go;
  logic        d_bad;
  logic        acc_fault;
  logic        rsp_valid;
  logic        rsp_fault;
  logic [31:0] busy_data;
  logic [31:0] rsp_data;
  // arbitration, fault screening, memory drive and response muxing
  always_comb begin
    own_ready = owner ? d_rsp_ready : if_rsp_ready;
    eligible = !reset && (state == IDLE || (state == BUSY && own_ready));
    d_win = eligible && d_req_valid && (DATA_PRIORITY || !if_req_valid);
    i_win = eligible && if_req_valid && !d_win;
    accept = d_win || i_win;
    d_bad = (d_funct3[1:0] == 2'b10 && d_addr[1:0] != 2'b00)
         || (d_funct3[1:0] == 2'b01 && d_addr[0])
         || (d_we ? (d_funct3[2] || d_funct3[1:0] == 2'b11) : d_funct3 inside {3'b011, 3'b110, 3'b111});
    acc_fault = d_win ? d_bad : if_addr[1:0] != 2'b00;
    go = accept && !acc_fault;
    mem_write_mem = go && d_win && d_we;
    mem_funct3 = (go && d_win) ? d_funct3 : 3'b010;
    mem_write_address = mem_write_mem ? d_addr : '0;
    mem_write_data = mem_write_mem ? d_wdata : '0;
    mem_read_address = (go && !(d_win && d_we)) ? (d_win ? d_addr : if_addr) : '0;
    if_req_ready = i_win;
    d_req_ready = d_win;
    busy_data = zero_data ? '0 : mem_read_data;
    rsp_valid = !reset && state != IDLE;
    rsp_data = state == HOLD ? hold_data : busy_data;
    rsp_fault = state == HOLD ? hold_fault : fault_q;
    if_rsp_valid = rsp_valid && !owner;
    d_rsp_valid = rsp_valid && owner;
    if_rsp_data = if_rsp_valid ? rsp_data : '0;
    d_rsp_data = d_rsp_valid ? rsp_data : '0;
    if_rsp_fault = if_rsp_valid && rsp_fault;
    d_rsp_fault = d_rsp_valid && rsp_fault;
  end
  // response FSM; read data is live only in the cycle after accept, so a stalled response is captured into hold
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      zero_data <= 1'b0;
      fault_q <= 1'b0;
      hold_data <= '0;
      hold_fault <= 1'b0;
    end else begin
      if (accept) begin
        owner <= d_win;
        zero_data <= acc_fault || (d_win && d_we);
        fault_q <= acc_fault;
      end
      if (state == BUSY && !own_ready) begin
        hold_data <= busy_data;
        hold_fault <= fault_q;
      end
      state <= accept ? BUSY
             : state == BUSY ? (own_ready ? IDLE : HOLD)
             : (state == HOLD && own_ready) ? IDLE : state;
    end
  end
endmodule

// File: doc/mem_initiator.md
# mem_initiator

Memory-bus initiator that sits between the RV32I core and the `memory` block. It arbitrates between an instruction-fetch port and a load/store port, and drives the memory's write-enable, funct3, write-address, write-data and read-address lines. It tracks the memory's one-cycle registered read latency, detects misaligned or illegal accesses before they reach memory, and returns one response per accepted request through a valid/ready handshake with a one-entry hold buffer.

## Interface
- `DATA_PRIORITY`, default 1: 1 gives the data port priority when both ports request in the same cycle; 0 gives the fetch port priority.
- One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req_valid`  in  1  fetch request.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_addr`  in  32  fetch address.
- `if_rsp_valid`  out  1  fetch response valid.
- `if_rsp_ready`  in  1  fetch response consumed.
- `if_rsp_data`  out  32  instruction word.
- `if_rsp_fault`  out  1  fetch was misaligned.
- `d_req_valid`  in  1  data request.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_we`  in  1  1 = store, 0 = load.
- `d_funct3`  in  3  RV32I load/store funct3.
- `d_addr`  in  32  byte address.
- `d_wdata`  in  32  store data, right-aligned.
- `d_rsp_valid`  out  1  data response valid.
- `d_rsp_ready`  in  1  data response consumed.
- `d_rsp_data`  out  32  load result, already extended by memory; 0 for stores and faults.
- `d_rsp_fault`  out  1  access was misaligned or illegal.
- `mem_write_mem`  out  1  memory write strobe.
- `mem_funct3`  out  3  access size and sign to memory.
- `mem_write_address`  out  32  memory write address.
- `mem_write_data`  out  32  memory write data.
- `mem_read_address`  out  32  memory read address.
- `mem_read_data`  in  32  memory read result, valid one cycle after the address.

## Operation
- States:
  - IDLE: no outstanding request.
  - BUSY: response is being presented, passed straight through from the memory path in the cycle after accept.
  - HOLD: response is being presented from the hold register.
- Accept-eligible cycles: IDLE, or BUSY with the owning port's `rsp_ready`=1. Never HOLD.
- Arbitration:
  - In an accept-eligible cycle, the winning valid port gets `req_ready`=1. The other port's ready is 0.
  - Ready may depend combinationally on valid.
- Accept actions, applied combinationally in the accept cycle:
  - Fetch: `mem_read_address`=`if_addr`, `mem_funct3`=3'b010.
  - Load: `mem_read_address`=`d_addr`, `mem_funct3`=`d_funct3`.
  - Store: `mem_write_mem`=1, `mem_write_address`=`d_addr`, `mem_write_data`=`d_wdata`, `mem_funct3`=`d_funct3`.
- Idle drive: when not accepting, `mem_write_mem`=0, `mem_funct3`=3'b010, all memory addresses and data = 0.
- Fault rules:
  - Fetch: `addr[1:0]`≠0.
  - Word access: `addr[1:0]`≠0.
  - Halfword access: `addr[0]`≠0.
  - Load funct3 ∈ {011, 110, 111}.
  - Store funct3 ∉ {000, 001, 010}.
- Fault handling: no memory strobe is issued; the response carries fault=1 and data=0.
- After accept: the block registers the owner, the kind (load / store / fetch) and the fault flag, then enters BUSY.
- In BUSY:
  - Owner `rsp_valid`=1.
  - Response data = `mem_read_data` for loads and fetches; 0 for stores and faults.
  - If owner `rsp_ready`=1: go to IDLE, or stay in BUSY if a new request is accepted in the same cycle.
  - If owner `rsp_ready`=0: capture data and fault into the hold register and go to HOLD.
- In HOLD: present the held values; when `rsp_ready`=1, go to IDLE.
- A non-owner port's `rsp_valid` is always 0.

## Timing
- Reset values:
  - State IDLE; hold register, owner and fault flag cleared.
  - All `rsp_valid`, `rsp_fault`, `rsp_data` = 0.
  - Both `req_ready` = 0 during reset.
  - `mem_write_mem`=0 throughout reset, so no store is issued in a reset cycle.
- Reset mid-operation drops any BUSY or HOLD response; it is never re-presented.
- Latency and throughput:
  - Request accepted in cycle N gives `rsp_valid` in N+1, for reads, stores and faults alike.
  - Sustained throughput is 1 per cycle while `rsp_ready` stays 1.
- HOLD adds at least one cycle: leaving HOLD spends a cycle in IDLE before the next accept.
- The hold register is needed because memory `read_data` is valid only in N+1. Later cycles must see the captured value, not the live bus.
- Accept and completion in the same cycle:
  - A BUSY completion plus a new accept by the other port is legal; the owner switches.
  - The previous owner's `rsp_valid` drops in the following cycle.

## Test plan
- Fetch of word 0x00000000 holding 0x00500093, `if_rsp_ready`=1: accept in cycle 0 → `if_rsp_data`=0x00500093, fault=0, valid in cycle 1.
- Both ports valid with `DATA_PRIORITY`=1, data is a sb of 0x1FF to 0xFFFFFFFD: data granted; `mem_write_mem`=1 with funct3 000 in the accept cycle; fetch granted the next cycle. A later lw of 0xFFFFFFFC returns 0x0000FF00.
- lh at address 0x00000003 → no memory strobe; response one cycle later with fault=1, data=0. Fetch at 0x00000002 → fault=1.
- Load of 0x000000F0 with `d_rsp_ready` held 0 for 3 cycles while memory's read data changes → `d_rsp_data` stays at the captured value (lbu of byte 0x80 → 0x00000080). `d_req_ready`=0 until the response is consumed.
- Back-to-back lw to 0x0, 0x4, 0x8 with `d_rsp_ready`=1 → three responses in consecutive cycles with the correct data.
- Assert reset in a HOLD cycle → the next cycle has all `rsp_valid`=0 and state IDLE. A store presented during reset produces no `mem_write_mem` pulse.
